// File: rtl/key_mode_sequencer_if.sv
// Key/mode bundle between the raw DE10-Lite keys, the mode sequencer and the output muxes.
interface key_mode_sequencer_if;
  logic [1:0] key_i;          // raw keys, active-low, asynchronous
  logic [1:0] mode_o;         // 0 arith, 1 logical, 2 compare, 3 blank
  logic       mode_changed_o; // one-cycle pulse with each new mode value
  logic [1:0] key_state_o;    // debounced keys, active-high

  modport slave  (input key_i, output mode_o, output mode_changed_o, output key_state_o);
  modport master (output key_i, input mode_o, input mode_changed_o, input key_state_o);
endinterface

// File: rtl/key_mode_sequencer.sv
// Synchronises and debounces the two mode keys and steps MODE once per press
// (KEY[0] up, KEY[1] down). Latency from first low sample to MODE is DEBOUNCE_CYCLES+3 edges.
module key_mode_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  key_mode_sequencer_if.slave   bus
);

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_CMP   = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  // The counter toggles the state on the edge it would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       sync_lvl;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       key_state_q, key_state_d;
  logic [1:0]       key_prev_q;
  logic [1:0]       press;
  logic [1:0]       mode_q, mode_d;
  logic             mode_changed_q, mode_changed_d;

  assign sync_lvl = ~sync2_q;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cnt_d[n]       = '0;
      key_state_d[n] = key_state_q[n];
      if (sync_lvl[n] != key_state_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          key_state_d[n] = ~key_state_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  assign press = key_state_q & ~key_prev_q;

  always_comb begin
    mode_d         = mode_q;
    mode_changed_d = 1'b0;
    if (press == 2'b01) begin
      mode_changed_d = 1'b1;
      case (mode_q)
        MODE_ARITH: mode_d = MODE_LOGIC;
        MODE_LOGIC: mode_d = MODE_CMP;
        MODE_CMP:   mode_d = MODE_BLANK;
        default:    mode_d = MODE_ARITH;
      endcase
    end else if (press == 2'b10) begin
      mode_changed_d = 1'b1;
      case (mode_q)
        MODE_ARITH: mode_d = MODE_BLANK;
        MODE_LOGIC: mode_d = MODE_ARITH;
        MODE_CMP:   mode_d = MODE_LOGIC;
        default:    mode_d = MODE_CMP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q        <= 2'b11;
      sync2_q        <= 2'b11;
      cnt_q          <= '{default: '0};
      key_state_q    <= 2'b00;
      key_prev_q     <= 2'b00;
      mode_q         <= MODE_ARITH;
      mode_changed_q <= 1'b0;
    end else begin
      sync1_q        <= bus.key_i;
      sync2_q        <= sync1_q;
      cnt_q          <= cnt_d;
      key_state_q    <= key_state_d;
      key_prev_q     <= key_state_q;
      mode_q         <= mode_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign bus.mode_o         = mode_q;
  assign bus.mode_changed_o = mode_changed_q;
  assign bus.key_state_o    = key_state_q;

endmodule
